// File: rtl/ip_tile_sequencer.sv
// Upstream command sequencer for ip_tile: issues one operand/opcode command, waits for completion or timeout, returns the result.
// Optional feature macro IP_TILE_SEQ_PERF_EN adds last_latency (ISSUE-entry to RESP-entry cycle count, saturating).
module ip_tile_sequencer #(
    parameter int CSR_IN_WIDTH   = 16,
    parameter int CSR_OUT_WIDTH  = 16,
    parameter int REG_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_op,
    input  logic [REG_WIDTH-1:0]     cmd_a,
    input  logic [REG_WIDTH-1:0]     cmd_b,
    output logic [CSR_IN_WIDTH-1:0]  csr_in,
    output logic                     csr_in_re,
    output logic [REG_WIDTH-1:0]     data_reg_a,
    output logic [REG_WIDTH-1:0]     data_reg_b,
    input  logic [CSR_OUT_WIDTH-1:0] csr_out,
    input  logic                     csr_out_we,
    input  logic [REG_WIDTH-1:0]     data_reg_c,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [REG_WIDTH-1:0]     rsp_data,
    output logic [CSR_OUT_WIDTH-1:0] rsp_status,
    output logic                     rsp_err
`ifdef IP_TILE_SEQ_PERF_EN
    ,
    output logic [15:0]              last_latency
`endif
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [7:0]       tag;
    logic [CNT_W-1:0] wait_count;
    logic             accept;
    logic             completion;
    logic             timeout;

    // Strobes from the tile only mean something while a command is outstanding.
    assign completion = csr_out_we && ((state == ISSUE) || (state == WAIT));
    assign timeout    = (state == WAIT) && (wait_count == CNT_LAST);
    assign accept     = cmd_valid && cmd_ready;

    assign cmd_ready  = (state == IDLE) && !rst;
    assign csr_in_re  = (state == ISSUE);
    assign rsp_valid  = (state == RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = completion ? RESP : WAIT;
            end
            WAIT: begin
                if (completion || timeout) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csr_in     <= '0;
            data_reg_a <= '0;
            data_reg_b <= '0;
            rsp_data   <= '0;
            rsp_status <= '0;
            rsp_err    <= 1'b0;
            tag        <= 8'd0;
            wait_count <= '0;
        end else begin
            if (accept) begin
                data_reg_a <= cmd_a;
                data_reg_b <= cmd_b;
                csr_in     <= CSR_IN_WIDTH'({cmd_op, tag});
            end

            if (state == ISSUE) begin
                wait_count <= '0;
            end else if (state == WAIT) begin
                wait_count <= wait_count + CNT_W'(1);
            end

            // Completion beats a coincident timeout on the last WAIT cycle.
            if (completion) begin
                rsp_data   <= data_reg_c;
                rsp_status <= csr_out;
                rsp_err    <= 1'b0;
            end else if (timeout) begin
                rsp_data   <= '0;
                rsp_status <= '0;
                rsp_err    <= 1'b1;
            end

            if ((state == RESP) && rsp_ready) begin
                tag <= tag + 8'd1;
            end
        end
    end

`ifdef IP_TILE_SEQ_PERF_EN
    logic [15:0] perf_count;

    // perf_count is 1 during ISSUE, so a completion in ISSUE reports a latency of 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_count   <= 16'd0;
            last_latency <= 16'd0;
        end else begin
            if (accept) begin
                perf_count <= 16'd1;
            end else if (((state == ISSUE) || (state == WAIT)) && (perf_count != 16'hFFFF)) begin
                perf_count <= perf_count + 16'd1;
            end
            if (completion || timeout) begin
                last_latency <= perf_count;
            end
        end
    end
`else
    // Default build carries no latency instrumentation.
`endif

endmodule

// File: tb/tb_ip_tile_sequencer.sv
// Self-checking bench for ip_tile_sequencer: transaction-level model, per-cycle compare, directed and randomized traffic.
module tb_ip_tile_sequencer;

    localparam int T = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [15:0] csr_in;
    logic        csr_in_re;
    logic [31:0] data_reg_a;
    logic [31:0] data_reg_b;
    logic [15:0] csr_out;
    logic        csr_out_we;
    logic [31:0] data_reg_c;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [15:0] rsp_status;
    logic        rsp_err;
`ifdef IP_TILE_SEQ_PERF_EN
    logic [15:0] last_latency;
`endif

    ip_tile_sequencer #(
        .CSR_IN_WIDTH  (16),
        .CSR_OUT_WIDTH (16),
        .REG_WIDTH     (32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .csr_in    (csr_in),
        .csr_in_re (csr_in_re),
        .data_reg_a(data_reg_a),
        .data_reg_b(data_reg_b),
        .csr_out   (csr_out),
        .csr_out_we(csr_out_we),
        .data_reg_c(data_reg_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_status(rsp_status),
        .rsp_err   (rsp_err)
`ifdef IP_TILE_SEQ_PERF_EN
        ,
        .last_latency(last_latency)
`endif
    );

    int          checks = 0;
    int          failures = 0;
    bit          chk_en = 1'b0;

    // Transaction-level model: busy = command accepted and response not yet taken,
    // pending = still waiting for completion/timeout, m_acc = cycle the command was accepted.
    int          cyc = 0;
    int          m_acc = 0;
    bit          m_busy = 1'b0;
    bit          m_pending = 1'b0;
    logic [7:0]  m_tag = 8'd0;
    logic [15:0] m_csr = 16'd0;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_b = 32'd0;
    logic [31:0] m_data = 32'd0;
    logic [15:0] m_status = 16'd0;
    bit          m_err = 1'b0;
    logic [15:0] m_lat = 16'd0;

    // Tile emulator controls.
    int          next_k = 0;
    int          tile_due = -1;
    int          idle_strobe_at = -1;
    bit          spurious_en = 1'b0;
    bit          tile_fix = 1'b0;
    logic [31:0] tile_c = 32'd0;
    logic [15:0] tile_s = 16'd0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] op,
                                 input logic [31:0] a, input logic [31:0] b, input logic rdy);
        @(negedge clk);
        rst       = r;
        cmd_valid = v;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        rsp_ready = rdy;
    endtask

    // Offset k after the ISSUE cycle: k=0 completes in ISSUE, k in 1..T lands in WAIT, k>T times out.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_busy    <= 1'b0;
            m_pending <= 1'b0;
            m_tag     <= 8'd0;
            m_csr     <= 16'd0;
            m_a       <= 32'd0;
            m_b       <= 32'd0;
            m_data    <= 32'd0;
            m_status  <= 16'd0;
            m_err     <= 1'b0;
            m_lat     <= 16'd0;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy    <= 1'b1;
                m_pending <= 1'b1;
                m_acc     <= cyc;
                m_a       <= cmd_a;
                m_b       <= cmd_b;
                m_csr     <= {cmd_op, m_tag};
                tile_due  <= cyc + 1 + next_k;
            end
        end else if (m_pending) begin
            if (csr_out_we) begin
                m_pending <= 1'b0;
                m_data    <= data_reg_c;
                m_status  <= csr_out;
                m_err     <= 1'b0;
                m_lat     <= 16'(cyc - m_acc);
            end else if (cyc - m_acc == T + 1) begin
                m_pending <= 1'b0;
                m_data    <= 32'd0;
                m_status  <= 16'd0;
                m_err     <= 1'b1;
                m_lat     <= 16'(cyc - m_acc);
            end
        end else if (rsp_ready) begin
            m_busy <= 1'b0;
            m_tag  <= m_tag + 8'd1;
        end
    end

    always @(negedge clk) begin
        csr_out_we = (cyc == tile_due) || (cyc == idle_strobe_at) ||
                     (spurious_en && !(m_busy && m_pending) && ($urandom_range(0, 3) == 0));
        if (tile_fix) begin
            data_reg_c = tile_c;
            csr_out    = tile_s;
        end else begin
            data_reg_c = $urandom;
            csr_out    = 16'($urandom);
        end
    end

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            checkOutput("cmd_ready",  32'(cmd_ready),  32'(!rst && !m_busy));
            checkOutput("csr_in_re",  32'(csr_in_re),  32'(m_busy && m_pending && (cyc == m_acc + 1)));
            checkOutput("rsp_valid",  32'(rsp_valid),  32'(m_busy && !m_pending));
            checkOutput("csr_in",     32'(csr_in),     32'(m_csr));
            checkOutput("data_reg_a", data_reg_a,      m_a);
            checkOutput("data_reg_b", data_reg_b,      m_b);
            checkOutput("rsp_data",   rsp_data,        m_data);
            checkOutput("rsp_status", 32'(rsp_status), 32'(m_status));
            checkOutput("rsp_err",    32'(rsp_err),    32'(m_err));
`ifdef IP_TILE_SEQ_PERF_EN
            checkOutput("last_latency", 32'(last_latency), 32'(m_lat));
`endif
        end
    end

    task automatic runTxn(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int k, input int ready_pct, input logic [7:0] exp_tag);
        int guard;
        bit done;
        next_k = k;
        applyStimulus(1'b0, 1'b1, op, a, b, 1'b0);
        #1;
        guard = 0;
        while (!cmd_ready && guard < 40) begin
            applyStimulus(1'b0, 1'b1, op, a, b, 1'b0);
            #1;
            guard++;
        end
        checkOutput("accept", 32'(cmd_ready), 32'd1);
        if (!cmd_ready) return;
        applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, ($urandom_range(0, 99) < ready_pct));
        #1;
        checkOutput("issued csr_in", 32'(csr_in), 32'({op, exp_tag}));
        checkOutput("issue strobe", 32'(csr_in_re), 32'd1);
        guard = 0;
        done  = rsp_valid && rsp_ready;
        while (!done && guard < 60) begin
            applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, ($urandom_range(0, 99) < ready_pct));
            #1;
            done = rsp_valid && rsp_ready;
            guard++;
        end
        checkOutput("response handshake", 32'(done), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] tag_ctr;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 8'd0;
        cmd_a     = 32'd0;
        cmd_b     = 32'd0;
        rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        #1;
        checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("post-reset cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("post-reset csr_in", 32'(csr_in), 32'd0);
        checkOutput("post-reset rsp_err", 32'(rsp_err), 32'd0);

        // First command, tile answers 3 cycles after the strobe; response then back-pressured 5 cycles.
        tile_fix = 1'b1;
        tile_c   = 32'h0000_000C;
        tile_s   = 16'h0001;
        next_k   = 3;
        applyStimulus(1'b0, 1'b1, 8'h12, 32'h5, 32'h7, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h34, 32'h11, 32'h22, 1'b0);
        #1;
        checkOutput("txn1 csr_in", 32'(csr_in), 32'h1200);
        checkOutput("txn1 csr_in_re", 32'(csr_in_re), 32'd1);
        checkOutput("txn1 data_reg_a", data_reg_a, 32'h5);
        checkOutput("txn1 data_reg_b", data_reg_b, 32'h7);
        applyStimulus(1'b0, 1'b1, 8'h34, 32'h11, 32'h22, 1'b0);
        #1;
        checkOutput("txn1 strobe single", 32'(csr_in_re), 32'd0);
        checkOutput("txn1 busy cmd_ready", 32'(cmd_ready), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'h34, 32'h11, 32'h22, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h34, 32'h11, 32'h22, 1'b0);
        #1;
        checkOutput("txn1 not yet valid", 32'(rsp_valid), 32'd0);
        next_k = 100;
        applyStimulus(1'b0, 1'b1, 8'h34, 32'h11, 32'h22, 1'b0);
        #1;
        checkOutput("txn1 rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("txn1 rsp_data", rsp_data, 32'hC);
        checkOutput("txn1 rsp_status", 32'(rsp_status), 32'h0001);
        checkOutput("txn1 rsp_err", 32'(rsp_err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h34, 32'h11, 32'h22, 1'b0);
            #1;
            checkOutput("hold cmd_ready", 32'(cmd_ready), 32'd0);
            checkOutput("hold rsp_data", rsp_data, 32'hC);
        end
        applyStimulus(1'b0, 1'b1, 8'h34, 32'h11, 32'h22, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h34, 32'h11, 32'h22, 1'b0);
        #1;
        checkOutput("txn2 accept", 32'(cmd_ready), 32'd1);

        // Second command never completes: timeout after T WAIT cycles.
        applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("txn2 csr_in tag", 32'(csr_in), 32'h3401);
        checkOutput("txn2 data_reg_a", data_reg_a, 32'h11);
        for (int i = 0; i < T; i++) begin
            applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
            #1;
            checkOutput("timeout wait", 32'(rsp_valid), 32'd0);
        end
        tile_c = 32'hBAD0_0BAD;
        tile_s = 16'h5A5A;
        applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b1);
        #1;
        checkOutput("timeout rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("timeout rsp_err", 32'(rsp_err), 32'd1);
        checkOutput("timeout rsp_data", rsp_data, 32'd0);
        checkOutput("timeout rsp_status", 32'(rsp_status), 32'd0);
        idle_strobe_at = cyc + 1;
        applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("idle strobe cmd_ready", 32'(cmd_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("idle strobe rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("idle strobe rsp_data", rsp_data, 32'd0);
        checkOutput("idle strobe rsp_err", 32'(rsp_err), 32'd1);

        // Completion on the last timeout cycle must win.
        tile_c = 32'hDEAD_BEEF;
        tile_s = 16'h00A5;
        next_k = T;
        applyStimulus(1'b0, 1'b1, 8'h56, 32'h1, 32'h2, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("coincide csr_in", 32'(csr_in), 32'h5602);
        for (int i = 0; i < T; i++) begin
            applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
        end
        #1;
        checkOutput("coincide not yet valid", 32'(rsp_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b1);
        #1;
        checkOutput("coincide rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("coincide rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("coincide rsp_data", rsp_data, 32'hDEAD_BEEF);
        checkOutput("coincide rsp_status", 32'(rsp_status), 32'h00A5);

        // Reset while waiting: everything clears, later strobe ignored, tag restarts at 0.
        next_k = 5;
        applyStimulus(1'b0, 1'b1, 8'h78, 32'h33, 32'h44, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("abort csr_in", 32'(csr_in), 32'd0);
        checkOutput("abort data_reg_a", data_reg_a, 32'd0);
        checkOutput("abort rsp_data", rsp_data, 32'd0);
        checkOutput("abort rsp_status", 32'(rsp_status), 32'd0);
        checkOutput("abort rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (3) applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("abort late strobe", 32'(rsp_valid), 32'd0);
        tile_fix = 1'b0;
        runTxn(8'h9A, 32'h55, 32'h66, 1, 100, 8'h00);

        // 257 back-to-back transactions from a fresh reset: tags 0x00..0xFF then 0x00.
        applyStimulus(1'b1, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 257; i++) begin
            runTxn(8'($urandom), $urandom, $urandom, $urandom_range(0, 2), 100, 8'(i));
        end

        // Randomized traffic with stray strobes, timeouts, back-pressure and occasional resets.
        spurious_en = 1'b1;
        tag_ctr = 8'd1;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                applyStimulus(1'b1, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
                tag_ctr = 8'd0;
            end
            repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
            runTxn(8'($urandom), $urandom, $urandom, $urandom_range(0, T + 3), 40, tag_ctr);
            tag_ctr = tag_ctr + 8'd1;
        end
        applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ip_tile_sequencer.md
Name: ip_tile_sequencer

Overview:
- Upstream command sequencer for ip_tile_user_name.
- Accepts operand/opcode commands over a valid/ready stream and drives the tile's data_reg_a, data_reg_b and csr_in/csr_in_re.
- Waits for the tile's csr_out_we completion, then captures csr_out and data_reg_c.
- Returns the captured values as a valid/ready response; a timeout guards against a hung tile.

Parameters:
- CSR_IN_WIDTH, 16, width of csr_in driven to the tile
- CSR_OUT_WIDTH, 16, width of csr_out captured from the tile
- REG_WIDTH, 32, width of data_reg_a/b/c
- TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before an error response (minimum 2)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  8  opcode placed in csr_in[15:8]
- cmd_a  input  REG_WIDTH  operand A
- cmd_b  input  REG_WIDTH  operand B
- csr_in  output  CSR_IN_WIDTH  to tile: {op[7:0], tag[7:0]}
- csr_in_re  output  1  to tile: one-cycle strobe, csr_in valid
- data_reg_a  output  REG_WIDTH  to tile
- data_reg_b  output  REG_WIDTH  to tile
- csr_out  input  CSR_OUT_WIDTH  from tile: status
- csr_out_we  input  1  from tile: completion strobe
- data_reg_c  input  REG_WIDTH  from tile: result
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  REG_WIDTH  captured data_reg_c
- rsp_status  output  CSR_OUT_WIDTH  captured csr_out
- rsp_err  output  1  1 = timeout, no completion seen

Behaviour:
- Single clock clk. rst is synchronous, active-high, and has priority over all other logic.
- Reset values: cmd_ready=0 during reset and 1 in the first IDLE cycle after. csr_in=0, csr_in_re=0, data_reg_a=0, data_reg_b=0, rsp_valid=0, rsp_data=0, rsp_status=0, rsp_err=0, tag=0, timeout count=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register cmd_a->data_reg_a, cmd_b->data_reg_b, {cmd_op,tag}->csr_in; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - csr_in_re=1; go to WAIT.
  - A csr_out_we in this cycle counts as completion: capture and go to RESP.
- WAIT:
  - Timeout counter starts at 0 and increments each WAIT cycle.
  - On csr_out_we: rsp_data<=data_reg_c, rsp_status<=csr_out, rsp_err<=0; go to RESP.
  - If count==TIMEOUT_CYCLES-1 with no csr_out_we: rsp_data<=0, rsp_status<=0, rsp_err<=1; go to RESP.
  - If completion and timeout occur in the same cycle, completion wins.
- RESP:
  - rsp_valid=1; payload held stable until rsp_valid&rsp_ready.
  - Then tag<=tag+1 (8-bit, wraps 255->0); go to IDLE.
- No pipelining: one transaction in flight; cmd_ready=0 outside IDLE.
- csr_out_we outside ISSUE/WAIT is ignored; state and outputs unchanged.
- data_reg_a, data_reg_b and csr_in hold their last values until the next command is accepted.
- Best-case latency:
  - Accept at cycle N.
  - csr_in_re at N+1.
  - Tile completion at earliest N+1.
  - rsp_valid at N+2.
- Reset mid-operation: abort to IDLE, all outputs return to reset values, the in-flight transaction is dropped, tag=0.

Optional Feature:
- Macro: IP_TILE_SEQ_PERF_EN.
- Defined:
  - Adds output port last_latency[15:0] (reset 0).
  - Holds the cycle count from ISSUE entry to RESP entry of the last transaction; saturates at 0xFFFF.
  - Updated on RESP entry, including timeouts.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release then cmd op=0x12, a=0x0000_0005, b=0x0000_0007; tile asserts csr_out_we 3 cycles after csr_in_re with data_reg_c=0x0000_000C, csr_out=0x0001 -> csr_in=0x1200 with a single-cycle csr_in_re; rsp_data=0xC, rsp_status=0x0001, rsp_err=0.
- TIMEOUT_CYCLES=8, tile never completes -> rsp_valid exactly 8 WAIT cycles after ISSUE; rsp_err=1, rsp_data=0, rsp_status=0.
- Hold rsp_ready=0 for 5 cycles with cmd_valid held high -> rsp payload stable, cmd_ready=0 throughout; the next command is accepted only after the handshake, and its csr_in[7:0]=0x01.
- 256 back-to-back transactions -> tag sequence 0x00..0xFF, and the 257th transaction carries csr_in[7:0]=0x00.
- Assert rst during WAIT -> next cycle all outputs are 0, state is IDLE; a later completion strobe is ignored and the next command uses tag 0.
- csr_out_we in IDLE, and completion coinciding with the last timeout cycle -> IDLE strobe has no effect; coincident case gives rsp_err=0 with captured data.
